// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the fetch-side control-flow logic.
//   XLEN_DEF / RESET_VEC_DEF : default datapath width and reset PC
//   SNT/WNT/WT/ST            : 2-bit saturating counter encodings
//   btb_meta_t               : per-entry control fields of a BTB slot
//   ctr_next()               : saturating counter step
package cpu_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    // Counter encodings: the MSB alone gives the predicted direction.
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Width-independent part of a BTB entry; tag and target live in
    // separate arrays because their widths depend on module parameters.
    typedef struct packed {
        logic       valid;
        logic       is_jump;
        logic [1:0] ctr;
    } btb_meta_t;

    // Move the counter one step toward the resolved direction, saturating.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        r = ctr;
        if (taken) begin
            if (ctr != ST) r = ctr + 2'd1;
        end else begin
            if (ctr != SNT) r = ctr - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_ram.sv
// btb_ram
// Direct-mapped branch target buffer: storage, combinational lookup,
// synchronous update and synchronous clear.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears valid, ctr=WNT)
//   rd_idx, rd_tag        lookup address (fetch PC fields)
//   rd_hit                valid entry with matching tag
//   rd_target             stored target of the indexed entry
//   rd_is_jump            entry holds an unconditional jump
//   rd_ctr_hi             counter MSB (predicted direction)
//   wr_en                 EX reports a resolved branch/jump this cycle
//   wr_idx, wr_tag        fields of the resolved instruction's PC
//   wr_taken, wr_is_jump  resolved direction and kind
//   wr_target             resolved target
module btb_ram
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int TAG_W = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [XLEN-1:0]  rd_target,
    output logic             rd_is_jump,
    output logic             rd_ctr_hi,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic             wr_is_jump,
    input  logic [XLEN-1:0]  wr_target
);

    btb_meta_t        meta_q   [DEPTH];
    btb_meta_t        meta_d   [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  target_d [DEPTH];
    logic             wr_hit;

    // Lookup reads the registered contents, so a same-cycle update to
    // the same slot is only seen by the following fetch.
    assign rd_hit     = meta_q[rd_idx].valid && (tag_q[rd_idx] == rd_tag);
    assign rd_target  = target_q[rd_idx];
    assign rd_is_jump = meta_q[rd_idx].is_jump;
    assign rd_ctr_hi  = meta_q[rd_idx].ctr[1];

    assign wr_hit = meta_q[wr_idx].valid && (tag_q[wr_idx] == wr_tag);

    // A hit trains the existing entry; a taken miss evicts whatever is in
    // the slot. Not-taken misses are not worth a slot and are dropped.
    always_comb begin
        meta_d   = meta_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            if (wr_hit) begin
                meta_d[wr_idx].ctr     = ctr_next(meta_q[wr_idx].ctr, wr_taken);
                meta_d[wr_idx].is_jump = wr_is_jump;
                if (wr_taken) target_d[wr_idx] = wr_target;
            end else if (wr_taken) begin
                meta_d[wr_idx]   = '{valid: 1'b1, is_jump: wr_is_jump, ctr: WT};
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = wr_target;
            end
        end
    end

    // Only the control fields need clearing; tag/target are don't-care
    // while valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                meta_q[i] <= '{valid: 1'b0, is_jump: 1'b0, ctr: WNT};
            end
        end else begin
            meta_q <= meta_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/pc_gen_bp.sv
// pc_gen_bp
// Fetch PC register with BTB-based next-PC prediction and EX-stage
// mispredict recovery.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall             hold the PC (ignored when EX mispredicts)
//   ex_valid          EX holds a resolved control-flow instruction
//   ex_pc             PC of that instruction
//   ex_is_branch      conditional branch
//   ex_is_jump        jal/jalr
//   ex_taken          resolved direction
//   ex_target         resolved target
//   ex_pred_taken     prediction made at fetch for that instruction
//   ex_pred_target    predicted target made at fetch
//   pc, pc4           current fetch PC and pc+4
//   pred_taken        prediction for the current pc
//   pred_target       predicted target for the current pc
//   flush             mispredict, kill IF/ID (combinational)
module pc_gen_bp
    import cpu_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int              BTB_DEPTH = 16,
    parameter int              BP_EN     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            flush
);

    localparam int   IDX_W = $clog2(BTB_DEPTH);
    localparam int   TAG_W = XLEN - IDX_W - 2;
    localparam logic BP_ON = (BP_EN != 0);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] ex_pc4;
    logic            ex_ctl;
    logic            mis;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic            btb_is_jump;
    logic            btb_ctr_hi;
    logic            hit_en;

    assign pc     = pc_q;
    assign pc4    = pc_q + XLEN'(4);
    assign ex_pc4 = ex_pc + XLEN'(4);
    assign ex_ctl = ex_valid && (ex_is_branch || ex_is_jump);

    // With BP_EN=0 the BTB never gets written and its hit is masked, so
    // the whole array is left dangling for synthesis to remove.
    btb_ram #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (pc_q[IDX_W+1:2]),
        .rd_tag     (pc_q[XLEN-1:IDX_W+2]),
        .rd_hit     (btb_hit),
        .rd_target  (btb_target),
        .rd_is_jump (btb_is_jump),
        .rd_ctr_hi  (btb_ctr_hi),
        .wr_en      (BP_ON && ex_ctl),
        .wr_idx     (ex_pc[IDX_W+1:2]),
        .wr_tag     (ex_pc[XLEN-1:IDX_W+2]),
        .wr_taken   (ex_taken),
        .wr_is_jump (ex_is_jump),
        .wr_target  (ex_target)
    );

    assign hit_en      = BP_ON && btb_hit;
    assign pred_taken  = rst_n && hit_en && (btb_is_jump || btb_ctr_hi);
    assign pred_target = hit_en ? btb_target : pc4;

    // A not-taken instruction only mispredicts on direction; the target
    // compare matters only when the instruction actually went somewhere.
    assign mis   = ex_ctl && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_target != ex_pred_target)));
    assign flush = rst_n && mis;

    // Recovery outranks stall: the stalled instruction is on the wrong
    // path and is being flushed anyway.
    always_comb begin
        pc_d = pc4;
        if (mis) begin
            pc_d = ex_taken ? ex_target : ex_pc4;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_gen_bp.sv
// tb_pc_gen_bp
// Drives a predicting instance and a BP_EN=0 instance with the same EX
// stream and compares both against a behavioural model each cycle.
module tb_pc_gen_bp;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] leg_pred_target;

    logic [31:0] pc_b, pc4_b, pred_target_b;
    logic        pred_taken_b, flush_b;
    logic [31:0] pc_l, pc4_l, pred_target_l;
    logic        pred_taken_l, flush_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_pc_b, m_pc_l;
    bit          pc_known = 0;
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    bit          m_jmp   [16];
    int          m_ctr   [16];
    bit          seen_flush;

    // The legacy instance always predicted not-taken / pc+4 at fetch.
    assign leg_pred_target = ex_pc + 32'd4;

    pc_gen_bp #(.BP_EN(1)) dut_bp (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pc(pc_b), .pc4(pc4_b), .pred_taken(pred_taken_b), .pred_target(pred_target_b),
        .flush(flush_b)
    );

    pc_gen_bp #(.BP_EN(0)) dut_leg (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(1'b0), .ex_pred_target(leg_pred_target),
        .pc(pc_l), .pc4(pc4_l), .pred_taken(pred_taken_l), .pred_target(pred_target_l),
        .flush(flush_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit br, input bit jmp, input bit tk,
                                 input logic [31:0] epc, input logic [31:0] tgt,
                                 input bit ptk, input logic [31:0] ptgt, input bit stl);
        ex_valid       = v;
        ex_is_branch   = br;
        ex_is_jump     = jmp;
        ex_taken       = tk;
        ex_pc          = epc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        stall          = stl;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    endtask

    // Model lookup: what the BTB says about address a.
    task automatic model_lookup(input logic [31:0] a, output bit tk, output logic [31:0] tgt);
        int  i;
        bit  hit;
        i   = int'((a >> 2) % 16);
        hit = m_valid[i] && (m_tag[i] == (a >> 6));
        tk  = hit && (m_jmp[i] || m_ctr[i] >= 2);
        tgt = hit ? m_tgt[i] : a + 32'd4;
    endtask

    // Check both instances against the model at the negedge, then advance
    // the model across the posedge.
    task automatic step_cycle();
        bit          ptk;
        logic [31:0] ptgt;
        bit          ctl, mis_b, mis_l;
        int          e;
        @(negedge clk);
        model_lookup(m_pc_b, ptk, ptgt);
        ptk   = ptk && rst_n;
        ctl   = ex_valid && (ex_is_branch || ex_is_jump);
        mis_b = ctl && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
        mis_l = ctl && ex_taken;
        seen_flush = flush_b;
        if (pc_known) begin
            checkOutput("pc_bp", pc_b, m_pc_b);
            checkOutput("pc4_bp", pc4_b, m_pc_b + 32'd4);
            checkOutput("pred_target_bp", pred_target_b, ptgt);
            checkOutput("pc_leg", pc_l, m_pc_l);
            checkOutput("pred_target_leg", pred_target_l, m_pc_l + 32'd4);
        end
        checkOutput("pred_taken_bp", {31'b0, pred_taken_b}, {31'b0, ptk});
        checkOutput("pred_taken_leg", {31'b0, pred_taken_l}, 32'h0);
        checkOutput("flush_bp", {31'b0, flush_b}, {31'b0, rst_n && mis_b});
        checkOutput("flush_leg", {31'b0, flush_l}, {31'b0, rst_n && mis_l});

        if (!rst_n) begin
            m_pc_b   = 32'h0;
            m_pc_l   = 32'h0;
            pc_known = 1;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
        end else begin
            if (mis_b)      m_pc_b = ex_taken ? ex_target : ex_pc + 32'd4;
            else if (stall) m_pc_b = m_pc_b;
            else if (ptk)   m_pc_b = ptgt;
            else            m_pc_b = m_pc_b + 32'd4;

            if (mis_l)      m_pc_l = ex_taken ? ex_target : ex_pc + 32'd4;
            else if (!stall) m_pc_l = m_pc_l + 32'd4;

            if (ctl) begin
                e = int'((ex_pc >> 2) % 16);
                if (m_valid[e] && m_tag[e] == (ex_pc >> 6)) begin
                    if (ex_taken) begin
                        m_tgt[e] = ex_target;
                        m_ctr[e] = (m_ctr[e] + 1 > 3) ? 3 : m_ctr[e] + 1;
                    end else begin
                        m_ctr[e] = (m_ctr[e] - 1 < 0) ? 0 : m_ctr[e] - 1;
                    end
                    m_jmp[e] = ex_is_jump;
                end else if (ex_taken) begin
                    m_valid[e] = 1;
                    m_tag[e]   = ex_pc >> 6;
                    m_tgt[e]   = ex_target;
                    m_ctr[e]   = 2;
                    m_jmp[e]   = ex_is_jump;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Force both instances to fetch from addr with a cold jump elsewhere.
    task automatic redirect_to(input logic [31:0] addr);
        applyStimulus(1, 0, 1, 1, 32'h0000_0F00, addr, 0, 32'h0000_0F04, 0);
        step_cycle();
        idle();
    endtask

    initial begin
        bit          rtk;
        logic [31:0] rtgt;
        logic [31:0] e_pc, e_tgt;
        bit          v, br, jmp, tk, ptk, stl;
        logic [31:0] ptgt;

        $display("[TB] pc_gen_bp bench start");
        rst_n = 1'b0;
        idle();

        // Reset, then free-run
        step_cycle();
        step_cycle();
        checkOutput("rst_pc", pc_b, 32'h0);
        checkOutput("rst_pred_taken", {31'b0, pred_taken_b}, 32'h0);
        rst_n = 1'b1;
        step_cycle(); checkOutput("run_pc4", pc_b, 32'h4);
        step_cycle(); checkOutput("run_pc8", pc_b, 32'h8);
        step_cycle(); checkOutput("run_pcC", pc_b, 32'hC);

        // Cold taken branch
        applyStimulus(1, 1, 0, 1, 32'h10, 32'h40, 0, 32'h14, 0);
        step_cycle();
        checkOutput("cold_flush", {31'b0, seen_flush}, 32'h1);
        checkOutput("cold_pc_bp", pc_b, 32'h40);
        checkOutput("cold_pc_leg", pc_l, 32'h40);
        idle();
        redirect_to(32'h10);
        checkOutput("cold_pred_taken", {31'b0, pred_taken_b}, 32'h1);
        checkOutput("cold_pred_target", pred_target_b, 32'h40);

        // Counter hysteresis
        applyStimulus(1, 1, 0, 1, 32'h10, 32'h40, 1, 32'h40, 0);
        step_cycle();
        checkOutput("hyst_train_flush", {31'b0, seen_flush}, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h10, 32'h40, 1, 32'h40, 0);
        step_cycle();
        checkOutput("hyst_nt1_flush", {31'b0, seen_flush}, 32'h1);
        checkOutput("hyst_nt1_pc", pc_b, 32'h14);
        redirect_to(32'h10);
        checkOutput("hyst_still_taken", {31'b0, pred_taken_b}, 32'h1);
        applyStimulus(1, 1, 0, 0, 32'h10, 32'h40, 1, 32'h40, 0);
        step_cycle();
        checkOutput("hyst_nt2_pc", pc_b, 32'h14);
        redirect_to(32'h10);
        checkOutput("hyst_now_nt", {31'b0, pred_taken_b}, 32'h0);

        // jalr target change
        applyStimulus(1, 0, 1, 1, 32'h20, 32'h100, 0, 32'h24, 0);
        step_cycle();
        applyStimulus(1, 0, 1, 1, 32'h20, 32'h200, 1, 32'h100, 0);
        step_cycle();
        checkOutput("jalr_flush", {31'b0, seen_flush}, 32'h1);
        checkOutput("jalr_pc", pc_b, 32'h200);
        redirect_to(32'h20);
        checkOutput("jalr_pred_taken", {31'b0, pred_taken_b}, 32'h1);
        checkOutput("jalr_pred_target", pred_target_b, 32'h200);

        // Stall holds, mispredict overrides stall
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            checkOutput("stall_pc", pc_b, 32'h20);
        end
        applyStimulus(1, 1, 0, 1, 32'h30, 32'h300, 0, 32'h34, 1);
        step_cycle();
        checkOutput("stall_mis_pc_bp", pc_b, 32'h300);
        checkOutput("stall_mis_pc_leg", pc_l, 32'h300);
        idle();

        // Tag alias: 0x50 shares the slot of 0x10
        redirect_to(32'h50);
        checkOutput("alias_pred_taken", {31'b0, pred_taken_b}, 32'h0);
        checkOutput("alias_pred_target", pred_target_b, 32'h54);

        // Address wrap
        redirect_to(32'hFFFF_FFFC);
        checkOutput("wrap_pc4", pc4_b, 32'h0);
        step_cycle();
        checkOutput("wrap_pc", pc_b, 32'h0);

        // Reset during a mispredict discards the redirect and clears the BTB
        applyStimulus(1, 1, 0, 1, 32'h10, 32'h80, 0, 32'h14, 0);
        rst_n = 1'b0;
        step_cycle();
        checkOutput("rst_mis_flush", {31'b0, seen_flush}, 32'h0);
        checkOutput("rst_mis_pc", pc_b, 32'h0);
        rst_n = 1'b1;
        idle();
        redirect_to(32'h10);
        checkOutput("rst_btb_cleared", {31'b0, pred_taken_b}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            e_pc  = ({30'b0, 2'($urandom_range(0, 3))} << 6) | ({28'b0, 4'($urandom_range(0, 15))} << 2);
            e_tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            v     = ($urandom_range(0, 99) < 60);
            jmp   = ($urandom_range(0, 3) == 0);
            br    = !jmp && ($urandom_range(0, 9) != 0);
            tk    = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                model_lookup(e_pc, rtk, rtgt);
                ptk  = rtk;
                ptgt = rtgt;
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = ($urandom_range(0, 1) == 1) ? e_tgt : e_pc + 32'd4;
            end
            stl   = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(v, br, jmp, tk, e_pc, e_tgt, ptk, ptgt, stl);
            step_cycle();
        end
        rst_n = 1'b1;
        idle();
        step_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_bp.md
Name: pc_gen_bp

Overview:
- Parametrised successor to the combinational next-PC selector.
- Owns the architectural fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch can predict taken branches and jumps.
- EX reports resolved control flow. On a mispredict the block redirects fetch and pulses flush.
- Sits between the IF stage and the EX-stage branch comparator and ALU (the ALU supplies the jalr target).

Parameters:
XLEN, 32, PC/target width
RESET_VEC, 32'h0000_0000, PC value loaded by reset
BTB_DEPTH, 16, BTB entries; power of two, minimum 2
BP_EN, 1, 1 = use BTB prediction; 0 = always predict not-taken (legacy behaviour: pc+4, redirect from EX only)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold PC (IF/ID hazard)
ex_valid  in  1  EX holds a resolved control-flow instruction this cycle
ex_pc  in  XLEN  PC of that instruction
ex_is_branch  in  1  conditional branch
ex_is_jump  in  1  jal/jalr (unconditional)
ex_taken  in  1  resolved direction (forced 1 by EX for jumps)
ex_target  in  XLEN  resolved target (pc_EX+offset, or alu_c for jalr)
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pred_target  in  XLEN  predicted target carried down the pipe
pc  out  XLEN  current fetch PC (registered)
pc4  out  XLEN  pc + 4
pred_taken  out  1  prediction for the current pc
pred_target  out  XLEN  predicted target for the current pc
flush  out  1  mispredict; kill IF/ID (combinational)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc <= RESET_VEC.
  - All BTB valid bits <= 0; counters <= 2'b01.
  - While rst_n=0: flush=0 and pred_taken=0.
  - Reset mid-redirect discards the redirect.
- Index and tag:
  - idx = pc[$clog2(BTB_DEPTH)+1:2].
  - tag = pc[XLEN-1:$clog2(BTB_DEPTH)+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target[XLEN], is_jump, ctr[1:0].
- Prediction (combinational from pc):
  - hit = valid && tag match.
  - pred_taken = BP_EN && hit && (is_jump || ctr[1]).
  - pred_target = hit ? entry target : pc4.
- Mispredict:
  - mis = ex_valid && (ex_is_branch||ex_is_jump) && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
  - flush = mis.
  - When ex_valid=0, ex_is_branch and ex_is_jump are ignored.
- Next PC, in priority order:
  - reset;
  - mis: ex_taken ? ex_target : ex_pc+4;
  - stall: pc unchanged;
  - pred_taken: pred_target;
  - otherwise pc+4.
- A mispredict overrides stall. Latency: redirect takes effect on the next edge (1 cycle).
- BTB update: on any edge with ex_valid && (ex_is_branch||ex_is_jump), independent of stall and mis, and only when BP_EN=1. Writes slot ex_pc's idx.
  - Hit: target <= ex_target when taken. Counter saturates: taken -> min(ctr+1, 3); not-taken -> max(ctr-1, 0). is_jump <= ex_is_jump.
  - Miss and taken: allocate, overwriting any entry. valid=1, new tag, target=ex_target, ctr = 2'b10, is_jump = ex_is_jump.
  - Miss and not-taken: no write.
- Same-index read and update in one cycle: prediction uses pre-update contents; the write is visible the next cycle.
- Arithmetic: all adds are XLEN-bit and wrap modulo 2^XLEN (pc=FFFF_FFFC -> pc4=0).
- BP_EN=0: BTB logic is tied off. pred_taken=0 and pred_target=pc4, so every taken branch or jump mispredicts.

Decomposition:
- Shared package (cpu_pkg):
  - XLEN_DEF and RESET_VEC_DEF constants.
  - BTB entry typedef.
  - Counter encoding constants: SNT=0, WNT=1, WT=2, ST=3.
- One sub-module, btb_ram: storage array, combinational lookup, synchronous update and reset clear.
- pc_gen_bp keeps the PC register, next-PC mux and mispredict compare.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> pc=0x0000_0000 and pred_taken=0; free-run 3 cycles -> pc=0x4, 0x8, 0xC.
- Cold taken branch: ex_pc=0x10, ex_is_branch=1, ex_taken=1, ex_target=0x40, ex_pred_taken=0 -> flush=1 that cycle, next pc=0x40. Later fetch at 0x10 -> pred_taken=1, pred_target=0x40.
- Counter hysteresis: train 0x10 taken to ctr=3, then report not-taken once -> still predicts taken (ctr=2) while flush=1 and next pc=0x14. Second not-taken -> pred_taken=0.
- jalr target change: jump at 0x20 trained to 0x100; EX reports target 0x200 with pred_target 0x100 -> flush=1, pc<=0x200, entry target becomes 0x200.
- Stall vs. mispredict: stall=1 with no mis -> pc held 3 cycles. stall=1 and mis in the same cycle -> redirect wins. Tag alias 0x10 vs 0x50 (BTB_DEPTH=16) -> no false hit.
- BP_EN=0 instance: same branch stream -> pred_taken never 1; every taken branch flushes; behaviour matches the legacy selector.
